// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package pipeline_pkg;
   localparam int MEM_TIMEOUT_DEF = 16;
   localparam int WAIT_W          = 8;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic idex_write;
      logic exmem_write;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;
   localparam ctrl_t CTRL_NORM = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                   exmem_write: 1'b1, default: 1'b0};
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register control outputs of the pipeline controller.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
   logic [4:0]       ID_Rs1, ID_Rs2, EX_Rd;
   logic             ID_UsesRs2, EX_MemRead, BranchTaken, DMemReq, DMemReady;
   logic             PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
   logic             IFIDFlush, IDEXFlush, MEMWBFlush;
   logic             MemTimeout;
   logic [CNT_W-1:0] StallCount, FlushCount;

   modport master (
      output ID_Rs1, ID_Rs2, EX_Rd, ID_UsesRs2, EX_MemRead, BranchTaken, DMemReq, DMemReady,
      input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBFlush,
             MemTimeout, StallCount, FlushCount
   );
   modport slave (
      input  ID_Rs1, ID_Rs2, EX_Rd, ID_UsesRs2, EX_MemRead, BranchTaken, DMemReq, DMemReady,
      output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBFlush,
             MemTimeout, StallCount, FlushCount
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory freeze with timeout halt.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = 32
) (
   input logic            clk,
   input logic            rst,
   pipeline_ctrl_if.slave bus
);
   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   ctrl_t             ctrl;
   logic              lu, fz, halt, stall_inc, flush_inc;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   always_comb begin
      lu = bus.EX_MemRead && (bus.EX_Rd != 5'd0) &&
           ((bus.EX_Rd == bus.ID_Rs1) || (bus.ID_UsesRs2 && (bus.EX_Rd == bus.ID_Rs2)));
      halt       = (state_q == ST_HALT);
      fz         = !halt && bus.DMemReq && !bus.DMemReady;
      ctrl       = CTRL_NORM;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
      state_d    = state_q;
      wait_cnt_d = '0;

      // Priority: halt > freeze > branch > load-use
      if (rst) begin
         ctrl = CTRL_IDLE;
      end else if (halt) begin
         ctrl      = CTRL_IDLE;
         stall_inc = 1'b1;
      end else if (fz) begin
         ctrl             = CTRL_IDLE;
         ctrl.memwb_flush = 1'b1;
         stall_inc        = 1'b1;
      end else if (bus.BranchTaken) begin
         ctrl.ifid_flush = 1'b1;
         ctrl.idex_flush = 1'b1;
         flush_inc       = 1'b1;
      end else if (lu) begin
         ctrl.pc_write   = 1'b0;
         ctrl.ifid_write = 1'b0;
         ctrl.idex_flush = 1'b1;
         stall_inc       = 1'b1;
      end

      // Halt on the edge where the count of consecutive freeze cycles reaches the limit
      if (!halt) begin
         if (fz) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            state_d    = (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) ? ST_HALT : ST_WAIT;
         end else begin
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk(clk), .rst(rst), .inc(stall_inc), .count(stall_cnt)
   );
   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk(clk), .rst(rst), .inc(flush_inc), .count(flush_cnt)
   );

   assign bus.PCWrite    = ctrl.pc_write;
   assign bus.IFIDWrite  = ctrl.ifid_write;
   assign bus.IDEXWrite  = ctrl.idex_write;
   assign bus.EXMEMWrite = ctrl.exmem_write;
   assign bus.IFIDFlush  = ctrl.ifid_flush;
   assign bus.IDEXFlush  = ctrl.idex_flush;
   assign bus.MEMWBFlush = ctrl.memwb_flush;
   assign bus.MemTimeout = halt;
   assign bus.StallCount = stall_cnt;
   assign bus.FlushCount = flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_ctrl;
   localparam int CNT_W = 4;
   // {PCWrite,IFIDWrite,IDEXWrite,EXMEMWrite,IFIDFlush,IDEXFlush,MEMWBFlush}
   localparam logic [6:0] C_NORM = 7'b1111000;
   localparam logic [6:0] C_LU   = 7'b0011010;
   localparam logic [6:0] C_BR   = 7'b1111110;
   localparam logic [6:0] C_FZ   = 7'b0000001;
   localparam logic [6:0] C_OFF  = 7'b0000000;

   logic clk, rst;
   int   checks, fails;

   pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();
   pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] ctrl_v();
      return {bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.EXMEMWrite,
              bus.IFIDFlush, bus.IDEXFlush, bus.MEMWBFlush};
   endfunction

   task automatic clr_in();
      bus.ID_Rs1 = 5'd0; bus.ID_Rs2 = 5'd0; bus.EX_Rd = 5'd0;
      bus.ID_UsesRs2 = 1'b0; bus.EX_MemRead = 1'b0; bus.BranchTaken = 1'b0;
      bus.DMemReq = 1'b0; bus.DMemReady = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clr_in();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst    = 1'b1;
      clr_in();
      #2;
      chk("rst_ctrl", 32'(ctrl_v()), 32'(C_OFF));
      chk("rst_stall", 32'(bus.StallCount), 0);
      chk("rst_flush", 32'(bus.FlushCount), 0);
      chk("rst_tmo", 32'(bus.MemTimeout), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("idle_ctrl", 32'(ctrl_v()), 32'(C_NORM));

      // load-use on Rs1: one bubble
      @(negedge clk);
      bus.EX_MemRead = 1'b1; bus.EX_Rd = 5'd5; bus.ID_Rs1 = 5'd5;
      #1 chk("lu_ctrl", 32'(ctrl_v()), 32'(C_LU));
      @(posedge clk); #1 chk("lu_stall", 32'(bus.StallCount), 1);
      @(negedge clk);
      clr_in();
      #1 chk("lu_after", 32'(ctrl_v()), 32'(C_NORM));
      // x0 destination and unused Rs2 never stall
      @(negedge clk);
      bus.EX_MemRead = 1'b1; bus.EX_Rd = 5'd0; bus.ID_Rs1 = 5'd0;
      #1 chk("lu_x0", 32'(ctrl_v()), 32'(C_NORM));
      @(negedge clk);
      bus.EX_Rd = 5'd5; bus.ID_Rs1 = 5'd3; bus.ID_Rs2 = 5'd5; bus.ID_UsesRs2 = 1'b0;
      #1 chk("lu_rs2_unused", 32'(ctrl_v()), 32'(C_NORM));
      @(negedge clk);
      bus.ID_UsesRs2 = 1'b1;
      #1 chk("lu_rs2_used", 32'(ctrl_v()), 32'(C_LU));
      @(posedge clk); #1 chk("lu_stall2", 32'(bus.StallCount), 2);

      // branch overrides load-use
      do_reset();
      bus.EX_MemRead = 1'b1; bus.EX_Rd = 5'd5; bus.ID_Rs1 = 5'd5; bus.BranchTaken = 1'b1;
      #1 chk("br_lu_ctrl", 32'(ctrl_v()), 32'(C_BR));
      @(posedge clk); #1;
      chk("br_lu_flush", 32'(bus.FlushCount), 1);
      chk("br_lu_stall", 32'(bus.StallCount), 0);

      // ready without request is ignored
      @(negedge clk);
      clr_in();
      bus.DMemReady = 1'b1;
      #1 chk("rdy_noreq", 32'(ctrl_v()), 32'(C_NORM));

      // memory timeout: freeze 4 cycles, then halt
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         if (i > 1) @(negedge clk);
         bus.DMemReq = 1'b1;
         #1;
         chk($sformatf("tmo_ctrl%0d", i), 32'(ctrl_v()), (i <= 4) ? 32'(C_FZ) : 32'(C_OFF));
         chk($sformatf("tmo_flag%0d", i), 32'(bus.MemTimeout), (i >= 5) ? 1 : 0);
      end
      @(posedge clk); #1 chk("tmo_stall", 32'(bus.StallCount), 8);
      @(negedge clk);
      bus.DMemReq = 1'b0;
      #1 chk("halt_sticky", 32'(ctrl_v()), 32'(C_OFF));
      rst = 1'b1;
      #1;
      chk("halt_rst_state", 32'(dut.state_q), 0);
      chk("halt_rst_stall", 32'(bus.StallCount), 0);
      chk("halt_rst_tmo", 32'(bus.MemTimeout), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("halt_rel_ctrl", 32'(ctrl_v()), 32'(C_NORM));

      // reset in the middle of a wait
      @(negedge clk);
      bus.DMemReq = 1'b1;
      @(negedge clk);
      #1 chk("wait_state", 32'(dut.state_q), 1);
      rst = 1'b1;
      #1;
      chk("wait_rst_state", 32'(dut.state_q), 0);
      chk("wait_rst_cnt", 32'(dut.wait_cnt_q), 0);
      @(negedge clk);
      rst = 1'b0;
      bus.DMemReq = 1'b0;
      #1 chk("wait_rel_ctrl", 32'(ctrl_v()), 32'(C_NORM));

      // branch held through a freeze takes effect on the ready cycle
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         if (i > 1) @(negedge clk);
         bus.DMemReq = 1'b1; bus.BranchTaken = 1'b1;
         #1 chk($sformatf("fzbr_ctrl%0d", i), 32'(ctrl_v()), 32'(C_FZ));
      end
      @(negedge clk);
      bus.DMemReady = 1'b1;
      #1 chk("fzbr_ready_ctrl", 32'(ctrl_v()), 32'(C_BR));
      @(posedge clk); #1;
      chk("fzbr_state", 32'(dut.state_q), 0);
      chk("fzbr_wcnt", 32'(dut.wait_cnt_q), 0);
      chk("fzbr_flush", 32'(bus.FlushCount), 1);
      chk("fzbr_stall", 32'(bus.StallCount), 3);

      // stall counter saturates at 15
      do_reset();
      bus.EX_MemRead = 1'b1; bus.EX_Rd = 5'd7; bus.ID_Rs1 = 5'd7;
      repeat (20) @(posedge clk);
      #1 chk("sat_stall", 32'(bus.StallCount), 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
